// File: rtl/dcache_tag_pkg.sv
// rtl/dcache_tag_pkg.sv - shared types and field helpers for the data-cache tag store
package dcache_tag_pkg;

  typedef enum logic [1:0] {
    SWEEP = 2'd0,
    IDLE  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  function automatic int entry_w(input int tag_width);
    return tag_width + 2;
  endfunction

  localparam int DEF_TAG_WIDTH = 22;
  localparam int DEF_ENTRY_W   = entry_w(DEF_TAG_WIDTH);
  localparam int DIRTY_BIT     = DEF_ENTRY_W - 1;
  localparam int VALID_BIT     = DEF_ENTRY_W - 2;

endpackage

// File: rtl/dcache_tag_sweep_fsm.sv
// rtl/dcache_tag_sweep_fsm.sv - invalidation sweep sequencer (post-reset and flush)
module dcache_tag_sweep_fsm
  import dcache_tag_pkg::*;
#(
  parameter  int SETS       = 16,
  localparam int ADDR_WIDTH = $clog2(SETS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush_req,
  output logic                  o_busy,
  output logic                  o_flush_done,
  output logic                  o_sweep_we,
  output logic [ADDR_WIDTH-1:0] o_sweep_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_SET = ADDR_WIDTH'(SETS - 1);

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_flush_done;

  state_e                w_state_nxt;
  logic [ADDR_WIDTH-1:0] w_cnt_nxt;
  logic                  w_flush_done_nxt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= SWEEP;
      r_cnt        <= '0;
      r_flush_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_flush_done <= w_flush_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_flush_done_nxt = 1'b0;
    case (r_state)
      SWEEP, FLUSH: begin
        // SETS is a power of two, so the increment wraps to 0 on the last set
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == LAST_SET) begin
          w_state_nxt      = IDLE;
          w_flush_done_nxt = (r_state == FLUSH);
        end
      end
      IDLE: begin
        if (i_flush_req) begin
          w_state_nxt = FLUSH;
        end
      end
      default: begin
        w_state_nxt = SWEEP;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_busy       = (r_state != IDLE);
  assign o_sweep_we   = (r_state != IDLE);
  assign o_sweep_addr = r_cnt;
  assign o_flush_done = r_flush_done;

endmodule

// File: rtl/dcache_tag_store.sv
// rtl/dcache_tag_store.sv - multi-way tag array with masked write, forwarding and self-clearing sweep
module dcache_tag_store
  import dcache_tag_pkg::*;
#(
  parameter  int WAYS       = 2,
  parameter  int SETS       = 16,
  parameter  int TAG_WIDTH  = 22,
  localparam int ADDR_WIDTH = $clog2(SETS),
  localparam int ENTRY_W    = entry_w(TAG_WIDTH),
  localparam int LINE_W     = WAYS * ENTRY_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [WAYS-1:0]       wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [LINE_W-1:0]     din0,
  output logic [LINE_W-1:0]     dout0,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [LINE_W-1:0]     dout1,
  input  logic                  flush_req,
  output logic                  busy,
  output logic                  flush_done
);

  logic [LINE_W-1:0]     r_mem [SETS];
  logic [ADDR_WIDTH-1:0] r_addr0;
  logic [ADDR_WIDTH-1:0] r_addr1;
  logic                  r_web0;
  logic [WAYS-1:0]       r_wmask0;
  logic [LINE_W-1:0]     r_din0;

  logic                  w_busy;
  logic                  w_flush_done;
  logic                  w_sweep_we;
  logic [ADDR_WIDTH-1:0] w_sweep_addr;
  logic [LINE_W-1:0]     w_dout0;
  logic [LINE_W-1:0]     w_dout1;

  dcache_tag_sweep_fsm #(
    .SETS (SETS)
  ) u_sweep_fsm (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_flush_req  (flush_req),
    .o_busy       (w_busy),
    .o_flush_done (w_flush_done),
    .o_sweep_we   (w_sweep_we),
    .o_sweep_addr (w_sweep_addr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr0  <= '0;
      r_addr1  <= '0;
      r_web0   <= 1'b1;
      r_wmask0 <= '0;
      r_din0   <= '0;
    end else if (!w_busy) begin
      if (flush_req) begin
        r_web0 <= 1'b1;
      end else begin
        if (!csb0) begin
          r_addr0  <= addr0;
          r_din0   <= din0;
          r_wmask0 <= wmask0;
          r_web0   <= web0;
        end else begin
          r_web0 <= 1'b1;
        end
        if (!csb1) begin
          r_addr1 <= addr1;
        end
      end
    end
  end

  // The sweep owns the array while busy; commits land only from IDLE captures
  always_ff @(posedge clk) begin
    if (w_sweep_we) begin
      r_mem[w_sweep_addr] <= '0;
    end else if (!r_web0) begin
      for (int w = 0; w < WAYS; w++) begin
        if (r_wmask0[w]) begin
          r_mem[r_addr0][w*ENTRY_W +: ENTRY_W] <= r_din0[w*ENTRY_W +: ENTRY_W];
        end
      end
    end
  end

  always_comb begin
    w_dout0 = r_mem[r_addr0];
    w_dout1 = r_mem[r_addr1];
    if (!r_web0) begin
      for (int w = 0; w < WAYS; w++) begin
        if (r_wmask0[w]) begin
          w_dout0[w*ENTRY_W +: ENTRY_W] = r_din0[w*ENTRY_W +: ENTRY_W];
          if (r_addr1 == r_addr0) begin
            w_dout1[w*ENTRY_W +: ENTRY_W] = r_din0[w*ENTRY_W +: ENTRY_W];
          end
        end
      end
    end
    if (w_busy) begin
      w_dout0 = '0;
      w_dout1 = '0;
    end
  end

  assign dout0      = w_dout0;
  assign dout1      = w_dout1;
  assign busy       = w_busy;
  assign flush_done = w_flush_done;

endmodule

// File: tb/tb_dcache_tag_store.sv
// tb/tb_dcache_tag_store.sv - self-checking bench for the data-cache tag store
module tb_dcache_tag_store;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        csb0 = 1'b1;
  logic        web0 = 1'b1;
  logic [1:0]  wmask0 = 2'b00;
  logic [3:0]  addr0 = 4'd0;
  logic [47:0] din0 = 48'h0;
  logic        csb1 = 1'b1;
  logic [3:0]  addr1 = 4'd0;
  logic        flush_req = 1'b0;
  logic [47:0] dout0;
  logic [47:0] dout1;
  logic        busy;
  logic        flush_done;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic        csb0;
    logic        web0;
    logic [1:0]  wmask0;
    logic [3:0]  addr0;
    logic [47:0] din0;
    logic        csb1;
    logic [3:0]  addr1;
    logic [47:0] e0;
    logic [47:0] e1;
  } vec_t;

  typedef struct {
    string       name;
    logic [47:0] e0;
    logic [47:0] e1;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[12];

  dcache_tag_store #(
    .WAYS      (2),
    .SETS      (16),
    .TAG_WIDTH (22)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .csb0       (csb0),
    .web0       (web0),
    .wmask0     (wmask0),
    .addr0      (addr0),
    .din0       (din0),
    .dout0      (dout0),
    .csb1       (csb1),
    .addr1      (addr1),
    .dout1      (dout1),
    .flush_req  (flush_req),
    .busy       (busy),
    .flush_done (flush_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c0, input logic w0, input logic [1:0] m0, input logic [3:0] a0,
                       input logic [47:0] d0, input logic c1, input logic [3:0] a1);
    csb0 = c0; web0 = w0; wmask0 = m0; addr0 = a0; din0 = d0; csb1 = c1; addr1 = a1;
  endtask

  task automatic pop_and_check();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 48'd1, 48'd0);
    end else begin
      e = sb.pop_front();
      check({e.name, "_dout0"}, dout0, e.e0);
      check({e.name, "_dout1"}, dout1, e.e1);
    end
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 2'b00, 4'(i), 48'h0, 1'b0, 4'(15 - i));
      sb.push_back('{$sformatf("%s_set%0d", tag, i), 48'h0, 48'h0});
      tick();
      pop_and_check();
    end
    drive(1'b1, 1'b1, 2'b00, 4'd0, 48'h0, 1'b1, 4'd0);
  endtask

  task automatic wait_idle(output int cycles, output int pulses);
    cycles = 0;
    pulses = 0;
    do begin
      tick();
      cycles++;
      if (flush_done) pulses++;
    end while (busy && cycles < 200);
  endtask

  initial begin
    int cyc;
    int pul;

    // write din0 layout: {way1 entry, way0 entry}, entry = {dirty, valid, tag}
    vecs[0]  = '{1'b0, 1'b1, 2'b00, 4'd0,  48'h000000_000000, 1'b0, 4'd15, 48'h000000_000000, 48'h000000_000000};
    vecs[1]  = '{1'b0, 1'b0, 2'b11, 4'd5,  48'hC3ABCD_400123, 1'b0, 4'd5,  48'hC3ABCD_400123, 48'hC3ABCD_400123};
    vecs[2]  = '{1'b0, 1'b1, 2'b00, 4'd5,  48'h000000_000000, 1'b0, 4'd5,  48'hC3ABCD_400123, 48'hC3ABCD_400123};
    vecs[3]  = '{1'b0, 1'b0, 2'b01, 4'd5,  48'hFFFFFF_7FFFFF, 1'b1, 4'd0,  48'hC3ABCD_7FFFFF, 48'hC3ABCD_7FFFFF};
    vecs[4]  = '{1'b1, 1'b1, 2'b00, 4'd0,  48'h000000_000000, 1'b0, 4'd5,  48'hC3ABCD_7FFFFF, 48'hC3ABCD_7FFFFF};
    vecs[5]  = '{1'b0, 1'b0, 2'b10, 4'd9,  48'h812345_ABCDEF, 1'b0, 4'd9,  48'h812345_000000, 48'h812345_000000};
    vecs[6]  = '{1'b1, 1'b0, 2'b11, 4'd1,  48'hFFFFFF_FFFFFF, 1'b0, 4'd9,  48'h812345_000000, 48'h812345_000000};
    vecs[7]  = '{1'b0, 1'b0, 2'b00, 4'd9,  48'hFFFFFF_FFFFFF, 1'b0, 4'd9,  48'h812345_000000, 48'h812345_000000};
    vecs[8]  = '{1'b0, 1'b1, 2'b00, 4'd9,  48'h000000_000000, 1'b0, 4'd0,  48'h812345_000000, 48'h000000_000000};
    vecs[9]  = '{1'b0, 1'b0, 2'b11, 4'd3,  48'h400001_400002, 1'b0, 4'd3,  48'h400001_400002, 48'h400001_400002};
    vecs[10] = '{1'b0, 1'b0, 2'b01, 4'd12, 48'h000000_C00FFF, 1'b0, 4'd12, 48'h000000_C00FFF, 48'h000000_C00FFF};
    vecs[11] = '{1'b0, 1'b1, 2'b00, 4'd3,  48'h000000_000000, 1'b0, 4'd12, 48'h400001_400002, 48'h000000_C00FFF};

    // Reset and post-reset sweep
    tick();
    tick();
    check("reset_busy", 48'(busy), 48'd1);
    check("reset_flush_done", 48'(flush_done), 48'd0);
    check("reset_dout0", dout0, 48'h0);
    check("reset_dout1", dout1, 48'h0);
    rst_n = 1'b1;
    wait_idle(cyc, pul);
    check("sweep_busy_cycles", 48'(cyc), 48'd16);
    check("sweep_flush_done_pulses", 48'(pul), 48'd0);
    read_all_zero("post_reset");

    // Table-driven read/write/forwarding vectors
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].csb0, vecs[i].web0, vecs[i].wmask0, vecs[i].addr0, vecs[i].din0,
            vecs[i].csb1, vecs[i].addr1);
      sb.push_back('{$sformatf("vec%0d", i), vecs[i].e0, vecs[i].e1});
      tick();
      pop_and_check();
    end

    // Flush with a simultaneous port-0 write that must be dropped
    drive(1'b0, 1'b0, 2'b11, 4'd7, 48'hFFFFFF_FFFFFF, 1'b1, 4'd0);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    drive(1'b1, 1'b1, 2'b00, 4'd0, 48'h0, 1'b1, 4'd0);
    check("flush_busy_entry", 48'(busy), 48'd1);
    check("flush_dout1_forced", dout1, 48'h0);
    check("flush_done_entry", 48'(flush_done), 48'd0);
    wait_idle(cyc, pul);
    check("flush_busy_cycles", 48'(cyc), 48'd16);
    check("flush_done_at_end", 48'(flush_done), 48'd1);
    tick();
    if (flush_done) pul++;
    check("flush_done_cleared", 48'(flush_done), 48'd0);
    check("flush_done_pulses", 48'(pul), 48'd1);
    read_all_zero("post_flush");

    // Reset asserted at flush cycle 7 aborts the flush without flush_done
    drive(1'b0, 1'b0, 2'b11, 4'd2, 48'hFFFFFF_FFFFFF, 1'b1, 4'd0);
    tick();
    drive(1'b1, 1'b1, 2'b00, 4'd0, 48'h0, 1'b1, 4'd0);
    tick();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    pul = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (flush_done) pul++;
    end
    check("abort_busy_mid_flush", 48'(busy), 48'd1);
    rst_n = 1'b0;
    tick();
    if (flush_done) pul++;
    check("abort_reset_busy", 48'(busy), 48'd1);
    rst_n = 1'b1;
    wait_idle(cyc, pul);
    check("abort_busy_cycles", 48'(cyc), 48'd16);
    tick();
    if (flush_done) pul++;
    check("abort_flush_done_pulses", 48'(pul), 48'd0);
    read_all_zero("post_abort");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
